// File: rtl/pipeline_pkg.sv
// Shared pipeline widths and the MEM-stage handshake state encoding.
package pipeline_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;

  typedef enum logic {
    StIdle = 1'b0,
    StBusy = 1'b1
  } mem_state_e;

endpackage

// File: rtl/memwbreg.sv
// MEM/WB pipeline register; a bubble clears the control bits while data fields hold.
module memwbreg
  import pipeline_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bubble,
  input  logic [DATA_W-1:0] alures_in,
  input  logic [REG_W-1:0]  rd_in,
  input  logic              memtoreg_in,
  input  logic              regwrite_in,
  input  logic              misalign_in,
  input  logic              buserr_in,
  input  logic              rdata_en,
  input  logic [DATA_W-1:0] rdata_in,
  output logic [DATA_W-1:0] memdata_wb,
  output logic [DATA_W-1:0] alures_wb,
  output logic [REG_W-1:0]  rd_wb,
  output logic              memtoreg_wb,
  output logic              regwrite_wb,
  output logic              misalign_wb,
  output logic              buserr_wb
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      memdata_wb  <= '0;
      alures_wb   <= '0;
      rd_wb       <= '0;
      memtoreg_wb <= 1'b0;
      regwrite_wb <= 1'b0;
      misalign_wb <= 1'b0;
      buserr_wb   <= 1'b0;
    end else if (bubble) begin
      memtoreg_wb <= 1'b0;
      regwrite_wb <= 1'b0;
      misalign_wb <= 1'b0;
      buserr_wb   <= 1'b0;
    end else begin
      alures_wb   <= alures_in;
      rd_wb       <= rd_in;
      memtoreg_wb <= memtoreg_in;
      regwrite_wb <= regwrite_in;
      misalign_wb <= misalign_in;
      buserr_wb   <= buserr_in;
      if (rdata_en) memdata_wb <= rdata_in;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: data-memory handshake with wait-state stall, timeout abort
// and misaligned-access trap, feeding the MEM/WB register.
module mem_stage
  import pipeline_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              zero_ex,
  input  logic              branch_ex,
  input  logic              memread_ex,
  input  logic              memwrite_ex,
  input  logic              memtoreg_ex,
  input  logic              regwrite_ex,
  input  logic [DATA_W-1:0] alures_ex,
  input  logic [DATA_W-1:0] b_ex,
  input  logic [REG_W-1:0]  rd_ex,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic              pcsrc,
  output logic              stall,
  output logic [DATA_W-1:0] memdata_wb,
  output logic [DATA_W-1:0] alures_wb,
  output logic [REG_W-1:0]  rd_wb,
  output logic              memtoreg_wb,
  output logic              regwrite_wb,
  output logic              misalign_wb,
  output logic              buserr_wb
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 15) ? $clog2(TIMEOUT_CYCLES) : 4;

  mem_state_e      state_q;
  logic [CntW-1:0] cnt_q;
  logic            access, misaligned, timeout_hit, read_done, fault;

  assign pcsrc      = branch_ex & zero_ex;
  assign access     = memread_ex | memwrite_ex;
  assign misaligned = access & (alures_ex[1:0] != 2'b00);

  // Gated by rst_n so the bus and stall drop the instant reset asserts.
  assign dmem_req    = rst_n & (((state_q == StIdle) & access & ~misaligned) |
                                (state_q == StBusy));
  assign dmem_we     = memwrite_ex;
  assign dmem_addr   = alures_ex;
  assign dmem_wdata  = b_ex;
  assign timeout_hit = (state_q == StBusy) & (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) & ~dmem_ack;
  assign stall       = dmem_req & ~dmem_ack & ~timeout_hit;
  // Write wins over read, so a combined read/write never captures read data.
  assign read_done   = dmem_req & dmem_ack & memread_ex & ~memwrite_ex;
  assign fault       = misaligned | timeout_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (access && !misaligned && !dmem_ack) begin
            state_q <= StBusy;
            cnt_q   <= '0;
          end
        end
        StBusy: begin
          if (dmem_ack || timeout_hit) begin
            state_q <= StIdle;
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  memwbreg u_memwbreg (
    .clk         (clk),
    .rst_n       (rst_n),
    .bubble      (stall),
    .alures_in   (alures_ex),
    .rd_in       (rd_ex),
    .memtoreg_in (memtoreg_ex & ~fault),
    .regwrite_in (regwrite_ex & ~fault),
    .misalign_in (misaligned),
    .buserr_in   (timeout_hit),
    .rdata_en    (read_done),
    .rdata_in    (dmem_rdata),
    .memdata_wb  (memdata_wb),
    .alures_wb   (alures_wb),
    .rd_wb       (rd_wb),
    .memtoreg_wb (memtoreg_wb),
    .regwrite_wb (regwrite_wb),
    .misalign_wb (misalign_wb),
    .buserr_wb   (buserr_wb)
  );

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        zero_ex, branch_ex, memread_ex, memwrite_ex, memtoreg_ex, regwrite_ex;
  logic [31:0] alures_ex, b_ex, dmem_addr, dmem_wdata, dmem_rdata, memdata_wb, alures_wb;
  logic [4:0]  rd_ex, rd_wb;
  logic        dmem_req, dmem_we, dmem_ack, pcsrc, stall;
  logic        memtoreg_wb, regwrite_wb, misalign_wb, buserr_wb;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT_CYCLES(15)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .zero_ex     (zero_ex),
    .branch_ex   (branch_ex),
    .memread_ex  (memread_ex),
    .memwrite_ex (memwrite_ex),
    .memtoreg_ex (memtoreg_ex),
    .regwrite_ex (regwrite_ex),
    .alures_ex   (alures_ex),
    .b_ex        (b_ex),
    .rd_ex       (rd_ex),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .dmem_rdata  (dmem_rdata),
    .dmem_ack    (dmem_ack),
    .pcsrc       (pcsrc),
    .stall       (stall),
    .memdata_wb  (memdata_wb),
    .alures_wb   (alures_wb),
    .rd_wb       (rd_wb),
    .memtoreg_wb (memtoreg_wb),
    .regwrite_wb (regwrite_wb),
    .misalign_wb (misalign_wb),
    .buserr_wb   (buserr_wb)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic m2r, input logic rw,
                       input logic [31:0] addr, input logic [31:0] bdat, input logic [4:0] rdst);
    memread_ex  = rd;
    memwrite_ex = wr;
    memtoreg_ex = m2r;
    regwrite_ex = rw;
    alures_ex   = addr;
    b_ex        = bdat;
    rd_ex       = rdst;
  endtask

  task automatic check_wb_zero(input string tag);
    check({tag, "_memdata"}, memdata_wb, 32'h0);
    check({tag, "_alures"}, alures_wb, 32'h0);
    check({tag, "_ctl"}, {27'h0, rd_wb == 5'd0, regwrite_wb, memtoreg_wb, misalign_wb, buserr_wb},
          32'h10);
  endtask

  initial begin
    rst_n = 1'b0;
    zero_ex = 1'b0; branch_ex = 1'b0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
    // Access presented during reset must not reach the bus.
    drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h100, 32'h0, 5'd3);
    tick(); tick();
    check("rst_req", {31'h0, dmem_req}, 32'h0);
    check("rst_stall", {31'h0, stall}, 32'h0);
    check_wb_zero("rst_wb");
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    rst_n = 1'b1;
    tick();

    // Zero-wait load.
    drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h100, 32'h0, 5'd5);
    dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF;
    #1;
    check("lw_req", {31'h0, dmem_req}, 32'h1);
    check("lw_stall", {31'h0, stall}, 32'h0);
    check("lw_we", {31'h0, dmem_we}, 32'h0);
    check("lw_addr", dmem_addr, 32'h100);
    tick();
    check("lw_memdata", memdata_wb, 32'hDEADBEEF);
    check("lw_regwrite", {31'h0, regwrite_wb}, 32'h1);
    check("lw_memtoreg", {31'h0, memtoreg_wb}, 32'h1);
    check("lw_rd", {27'h0, rd_wb}, 32'd5);
    check("lw_alures", alures_wb, 32'h100);

    // Store with both read and write set; ack after three stall cycles.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h204, 32'h12345678, 5'd0);
    dmem_ack = 1'b0; dmem_rdata = 32'hBAD0BAD0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("sw_stall%0d", i), {31'h0, stall}, 32'h1);
      check($sformatf("sw_we%0d", i), {31'h0, dmem_we}, 32'h1);
      check($sformatf("sw_wdata%0d", i), dmem_wdata, 32'h12345678);
      tick();
      check($sformatf("sw_bubble%0d", i), {30'h0, regwrite_wb, memtoreg_wb}, 32'h0);
      check($sformatf("sw_hold%0d", i), alures_wb, 32'h100);
    end
    dmem_ack = 1'b1;
    #1;
    check("sw_ack_req", {31'h0, dmem_req}, 32'h1);
    check("sw_ack_stall", {31'h0, stall}, 32'h0);
    tick();
    check("sw_regwrite", {31'h0, regwrite_wb}, 32'h0);
    check("sw_alures", alures_wb, 32'h204);
    check("sw_no_rdata", memdata_wb, 32'hDEADBEEF);

    // Misaligned load.
    drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h102, 32'h0, 5'd7);
    dmem_ack = 1'b0;
    #1;
    check("mis_req", {31'h0, dmem_req}, 32'h0);
    check("mis_stall", {31'h0, stall}, 32'h0);
    tick();
    check("mis_flag", {29'h0, misalign_wb, regwrite_wb, memtoreg_wb}, 32'h4);
    check("mis_alures", alures_wb, 32'h102);

    // Stray ack with no access.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    dmem_ack = 1'b1; dmem_rdata = 32'h55555555;
    #1;
    check("stray_req", {31'h0, dmem_req}, 32'h0);
    tick();
    check("stray_memdata", memdata_wb, 32'hDEADBEEF);
    check("stray_misalign", {31'h0, misalign_wb}, 32'h0);

    // Load that never gets acked, with a taken branch alongside.
    drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h300, 32'h0, 5'd9);
    dmem_ack = 1'b0; branch_ex = 1'b1; zero_ex = 1'b1;
    for (int i = 0; i < 15; i++) begin
      #1;
      check($sformatf("to_stall%0d", i), {31'h0, stall}, 32'h1);
      check($sformatf("to_pcsrc%0d", i), {31'h0, pcsrc}, 32'h1);
      tick();
    end
    #1;
    check("to_hit_stall", {31'h0, stall}, 32'h0);
    check("to_hit_req", {31'h0, dmem_req}, 32'h1);
    tick();
    check("to_buserr", {29'h0, buserr_wb, regwrite_wb, memtoreg_wb}, 32'h4);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    zero_ex = 1'b0;
    #1;
    check("to_idle_req", {31'h0, dmem_req}, 32'h0);
    check("br_not_taken", {31'h0, pcsrc}, 32'h0);
    tick();
    check("to_buserr_clr", {31'h0, buserr_wb}, 32'h0);
    branch_ex = 1'b0;

    // Reset in the second BUSY cycle.
    drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h500, 32'h0, 5'd4);
    tick(); tick();
    #1;
    check("rb_stall_pre", {31'h0, stall}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("rb_req", {31'h0, dmem_req}, 32'h0);
    check("rb_stall", {31'h0, stall}, 32'h0);
    check_wb_zero("rb_wb");
    tick(); tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("rb_noretry%0d", i), {31'h0, dmem_req}, 32'h0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
